sample_scheduler: RTL and testbench
===================================

SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter WORD_LENGTH, 16, width of converter and sample data.
REQ-002 Parameter SYSTEM_FREQUENCY, 100000000, clock_i frequency in Hz.
REQ-003 Parameter SAMPLING_FREQUENCY, 1000000, tick rate in Hz; DIV = SYSTEM_FREQUENCY/SAMPLING_FREQUENCY SHALL be an integer >= 4.
REQ-004 Parameter NUM_CHANNELS, 4, number of converter channels; CH_W = max(1, $clog2(NUM_CHANNELS)).
REQ-005 Parameter TIMEOUT_CYCLES, 64, maximum wait for converter data.
REQ-006 clock_i  input  1  system clock; all logic on its rising edge.
REQ-007 reset_n_i  input  1  reset, synchronous, active-low.
REQ-008 enable_i  input  1  run scheduler; low = hold idle.
REQ-009 clear_i  input  1  one-cycle pulse; clears sticky flags.
REQ-010 channel_mask_i  input  NUM_CHANNELS  bit n high = channel n is sampled.
REQ-011 conv_start_o  output  1  one-cycle conversion request.
REQ-012 conv_channel_o  output  CH_W  channel for current conversion.
REQ-013 conv_valid_i  input  1  converter result strobe.
REQ-014 conv_data_i  input  WORD_LENGTH  converter result.
REQ-015 tick_o  output  1  one-cycle sampling tick.
REQ-016 sample_valid_o  output  1  one-cycle new-sample strobe.
REQ-017 sample_data_o  output  WORD_LENGTH  last captured sample.
REQ-018 sample_channel_o  output  CH_W  channel of last captured sample.
REQ-019 overrun_o  output  1  sticky: tick arrived while a conversion was in progress.
REQ-020 timeout_o  output  1  sticky: converter failed to respond.

Function
REQ-021 Prescaler counts 0..DIV-1 while enable_i=1; tick_o=1 for exactly the cycle count==DIV-1, then count wraps to 0; first tick is DIV cycles after enable_i rises.
REQ-022 FSM states: IDLE, WAIT_TICK, START, WAIT_DATA.
REQ-023 IDLE -> WAIT_TICK when enable_i=1; any state -> IDLE the cycle after enable_i=0, clearing the prescaler and abandoning any conversion; sample_data_o, sample_channel_o and sticky flags are kept.
REQ-024 WAIT_TICK on tick_o: if channel_mask_i != 0, select the next set mask bit strictly after last_channel, wrapping NUM_CHANNELS-1 -> 0, and go to START; if mask == 0, remain and discard the tick.
REQ-025 START: conv_start_o=1 and conv_channel_o=selected for exactly this one cycle (tick in cycle T -> start in T+1); next state WAIT_DATA.
REQ-026 WAIT_DATA: conv_valid_i=1 in cycle V -> capture conv_data_i; sample_valid_o=1 in V+1 with sample_data_o/sample_channel_o updated; last_channel := selected; go to WAIT_TICK.
REQ-027 WAIT_DATA timeout counter starts at 0 on entry; after TIMEOUT_CYCLES cycles without conv_valid_i, set timeout_o, set last_channel := selected (channel skipped), go to WAIT_TICK; no sample_valid_o.
REQ-028 tick_o while state is START or WAIT_DATA -> overrun_o set, tick dropped, current conversion continues.
REQ-029 conv_valid_i outside WAIT_DATA is ignored.
REQ-030 Simultaneous tick_o and conv_valid_i in WAIT_DATA: sample captured per REQ-026 and overrun_o set.
REQ-031 clear_i clears overrun_o/timeout_o; a set event in the same cycle as clear_i wins (flag reads 1).
REQ-032 channel_mask_i is sampled only at the selection cycle; later changes do not affect an in-progress conversion.
REQ-033 sample_data_o and sample_channel_o hold their value between strobes.

Reset
REQ-034 reset_n_i=0 at a clock edge: state IDLE, prescaler 0, timeout counter 0, last_channel = NUM_CHANNELS-1 (first selection is the lowest set bit), all outputs 0.
REQ-035 Reset mid-conversion abandons it with no sample_valid_o; reset has priority over enable_i and clear_i.

Verification (DIV=10 via SYSTEM_FREQUENCY=1000, SAMPLING_FREQUENCY=100; NUM_CHANNELS=4; TIMEOUT_CYCLES=8)
REQ-036 Mask 4'b1011, converter replies 3 cycles after start with data 16'h1234 -> conv_channel_o sequence 0,1,3,0,... one per tick, sample_valid_o 1 cycle after each reply, sample_data_o=16'h1234.
REQ-037 enable_i rises at cycle 0 -> tick_o at cycles 10,20,30; conv_start_o at 11,21,31; mask 0 -> no conv_start_o.
REQ-038 Converter never replies -> timeout_o=1 at start+9; next tick starts the next masked channel; clear_i -> timeout_o=0 next cycle.
REQ-039 Converter replies 12 cycles after start -> overrun_o=1 at the tick, sample still delivered, the next start only follows the tick after that.
REQ-040 reset_n_i=0 for 1 cycle during WAIT_DATA, then a late conv_valid_i -> no sample_valid_o; all outputs 0; first post-reset selection is channel 0.
REQ-041 enable_i dropped during WAIT_DATA -> IDLE next cycle, tick_o stays 0, sample_data_o unchanged.

Source files
------------

// File: rtl/sample_scheduler.sv
// Tick-driven round-robin conversion scheduler: one converter request per tick over the masked channels.
// Start follows the tick by one cycle, the sample strobe follows the converter reply by one cycle; no backpressure.
module sample_scheduler #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000,
  parameter int NUM_CHANNELS       = 4,
  parameter int TIMEOUT_CYCLES     = 64,
  localparam int DIV  = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [NUM_CHANNELS-1:0] channel_mask_i,
  output logic                    conv_start_o,
  output logic [CH_W-1:0]         conv_channel_o,
  input  logic                    conv_valid_i,
  input  logic [WORD_LENGTH-1:0]  conv_data_i,
  output logic                    tick_o,
  output logic                    sample_valid_o,
  output logic [WORD_LENGTH-1:0]  sample_data_o,
  output logic [CH_W-1:0]         sample_channel_o,
  output logic                    overrun_o,
  output logic                    timeout_o
);

  localparam int CNT_W = $clog2(DIV);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, START, WAIT_DATA} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       presc_q, presc_d;
  logic [TO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [CH_W-1:0]        last_ch_q, last_ch_d;
  logic [CH_W-1:0]        sel_q, sel_d;
  logic [CH_W-1:0]        smp_ch_q, smp_ch_d;
  logic [WORD_LENGTH-1:0] smp_dat_q, smp_dat_d;
  logic                   smp_vld_q, smp_vld_d;
  logic                   ovr_q, ovr_d;
  logic                   tmo_q, tmo_d;
  logic                   tick;
  logic                   ovr_set;
  logic                   tmo_set;
  logic [CH_W-1:0]        next_ch;
  logic [CH_W-1:0]        hi_ch;
  logic [CH_W-1:0]        lo_ch;
  logic                   hi_found;

  assign tick = enable_i && (state_q != IDLE) && (presc_q == CNT_W'(DIV - 1));

  // Lowest set bit above last_ch wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    hi_ch    = '0;
    lo_ch    = '0;
    hi_found = 1'b0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (channel_mask_i[c]) begin
        lo_ch = CH_W'(c);
        if (c > int'(last_ch_q)) begin
          hi_ch    = CH_W'(c);
          hi_found = 1'b1;
        end
      end
    end
    next_ch = hi_found ? hi_ch : lo_ch;
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = '0;
    tmo_cnt_d = tmo_cnt_q;
    last_ch_d = last_ch_q;
    sel_d     = sel_q;
    smp_ch_d  = smp_ch_q;
    smp_dat_d = smp_dat_q;
    smp_vld_d = 1'b0;
    ovr_set   = 1'b0;
    tmo_set   = 1'b0;

    if (enable_i && (state_q != IDLE)) begin
      presc_d = (presc_q == CNT_W'(DIV - 1)) ? '0 : presc_q + CNT_W'(1);
    end

    if (!enable_i) begin
      state_d   = IDLE;
      tmo_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_TICK;
        WAIT_TICK: begin
          if (tick && (|channel_mask_i)) begin
            sel_d   = next_ch;
            state_d = START;
          end
        end
        START: begin
          ovr_set   = tick;
          tmo_cnt_d = '0;
          state_d   = WAIT_DATA;
        end
        WAIT_DATA: begin
          ovr_set = tick;
          if (conv_valid_i) begin
            smp_dat_d = conv_data_i;
            smp_ch_d  = sel_q;
            smp_vld_d = 1'b1;
            last_ch_d = sel_q;
            state_d   = WAIT_TICK;
          end else if (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_set   = 1'b1;
            last_ch_d = sel_q;
            state_d   = WAIT_TICK;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TO_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ovr_d = ovr_set | (ovr_q & ~clear_i);
    tmo_d = tmo_set | (tmo_q & ~clear_i);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      tmo_cnt_q <= '0;
      last_ch_q <= CH_W'(NUM_CHANNELS - 1);
      sel_q     <= '0;
      smp_ch_q  <= '0;
      smp_dat_q <= '0;
      smp_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tmo_cnt_q <= tmo_cnt_d;
      last_ch_q <= last_ch_d;
      sel_q     <= sel_d;
      smp_ch_q  <= smp_ch_d;
      smp_dat_q <= smp_dat_d;
      smp_vld_q <= smp_vld_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
    end
  end

  assign conv_start_o     = (state_q == START);
  assign conv_channel_o   = sel_q;
  assign tick_o           = tick;
  assign sample_valid_o   = smp_vld_q;
  assign sample_data_o    = smp_dat_q;
  assign sample_channel_o = smp_ch_q;
  assign overrun_o        = ovr_q;
  assign timeout_o        = tmo_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: two instances (timeout 8 and 16) share all stimulus and are
// compared every cycle against an arithmetic reference model built from cycle numbers.
module tb_sample_scheduler;

  localparam int DIV = 10;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [3:0]  mask_i = 4'b0000;
  logic        conv_valid_i = 1'b0;
  logic [15:0] conv_data_i = 16'h0000;

  logic [1:0]  tick_w, cs_w, sv_w, ovr_w, tmo_w;
  logic [1:0]  cch_w [2];
  logic [1:0]  sch_w [2];
  logic [15:0] sd_w  [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // stimulus controls
  int reply_delay = 0;
  int reply_at = -1;
  bit rand_delay = 1'b0;
  bit data_fixed = 1'b0;
  bit spur_en = 1'b0;

  // reference model state, per instance
  bit m_run [2];
  int m_run_start [2];
  bit m_busy [2];
  int m_start_at [2];
  int m_ch [2];
  int m_last [2];
  bit m_sv [2];
  int m_sd [2];
  int m_sc [2];
  bit m_ovr [2];
  bit m_tmo [2];
  bit e_tick, e_start, ovr_set, tmo_set;

  // monitors
  int st_ch0[$];
  int tick_cnt0 = 0;
  int first_tick0 = -1;
  int sv_cnt1 = 0;

  always #5 clk = ~clk;

  sample_scheduler #(
    .WORD_LENGTH(16), .SYSTEM_FREQUENCY(1000), .SAMPLING_FREQUENCY(100),
    .NUM_CHANNELS(NCH), .TIMEOUT_CYCLES(8)
  ) dut0 (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable_i), .clear_i(clear_i),
    .channel_mask_i(mask_i), .conv_start_o(cs_w[0]), .conv_channel_o(cch_w[0]),
    .conv_valid_i(conv_valid_i), .conv_data_i(conv_data_i), .tick_o(tick_w[0]),
    .sample_valid_o(sv_w[0]), .sample_data_o(sd_w[0]), .sample_channel_o(sch_w[0]),
    .overrun_o(ovr_w[0]), .timeout_o(tmo_w[0])
  );

  sample_scheduler #(
    .WORD_LENGTH(16), .SYSTEM_FREQUENCY(1000), .SAMPLING_FREQUENCY(100),
    .NUM_CHANNELS(NCH), .TIMEOUT_CYCLES(16)
  ) dut1 (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(enable_i), .clear_i(clear_i),
    .channel_mask_i(mask_i), .conv_start_o(cs_w[1]), .conv_channel_o(cch_w[1]),
    .conv_valid_i(conv_valid_i), .conv_data_i(conv_data_i), .tick_o(tick_w[1]),
    .sample_valid_o(sv_w[1]), .sample_data_o(sd_w[1]), .sample_channel_o(sch_w[1]),
    .overrun_o(ovr_w[1]), .timeout_o(tmo_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int to_of(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic int next_after(input int last, input int mask);
    for (int i = 1; i <= NCH; i++) begin
      if (((mask >> ((last + i) % NCH)) & 1) != 0) return (last + i) % NCH;
    end
    return last;
  endfunction

  function automatic int pick_delay();
    int tbl [8] = '{1, 2, 3, 5, 9, 12, 17, 0};
    return tbl[$urandom_range(0, 7)];
  endfunction

  // Reference model: check the current cycle's outputs, then advance to the next cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_tick  = m_run[k] && enable_i && (((cyc - m_run_start[k]) % DIV) == DIV - 1);
      e_start = m_busy[k] && (cyc == m_start_at[k]);
      if (chk_on) begin
        chk($sformatf("tick%0d", k),  tick_w[k], e_tick);
        chk($sformatf("start%0d", k), cs_w[k],   e_start);
        chk($sformatf("cch%0d", k),   cch_w[k],  m_ch[k]);
        chk($sformatf("svld%0d", k),  sv_w[k],   m_sv[k]);
        chk($sformatf("sdat%0d", k),  sd_w[k],   m_sd[k]);
        chk($sformatf("sch%0d", k),   sch_w[k],  m_sc[k]);
        chk($sformatf("ovr%0d", k),   ovr_w[k],  m_ovr[k]);
        chk($sformatf("tmo%0d", k),   tmo_w[k],  m_tmo[k]);
      end
      if (k == 1 && e_start) begin
        reply_delay = rand_delay ? pick_delay() : reply_delay;
        reply_at = (reply_delay > 0) ? cyc + reply_delay : -1;
      end
      if (!rst_n) begin
        m_run[k] = 0; m_busy[k] = 0; m_ch[k] = 0; m_last[k] = NCH - 1;
        m_sv[k] = 0; m_sd[k] = 0; m_sc[k] = 0; m_ovr[k] = 0; m_tmo[k] = 0;
      end else begin
        ovr_set = 0;
        tmo_set = 0;
        m_sv[k] = 0;
        if (!m_run[k]) begin
          if (enable_i) begin
            m_run[k] = 1;
            m_run_start[k] = cyc + 1;
          end
        end else if (!enable_i) begin
          m_run[k] = 0;
          m_busy[k] = 0;
        end else if (m_busy[k]) begin
          ovr_set = e_tick;
          if (cyc > m_start_at[k]) begin
            if (conv_valid_i) begin
              m_sv[k] = 1; m_sd[k] = conv_data_i; m_sc[k] = m_ch[k];
              m_last[k] = m_ch[k]; m_busy[k] = 0;
            end else if (cyc - m_start_at[k] == to_of(k)) begin
              tmo_set = 1; m_last[k] = m_ch[k]; m_busy[k] = 0;
            end
          end
        end else if (e_tick && mask_i != 0) begin
          m_ch[k] = next_after(m_last[k], mask_i);
          m_busy[k] = 1;
          m_start_at[k] = cyc + 1;
        end
        m_ovr[k] = ovr_set | (m_ovr[k] & !clear_i);
        m_tmo[k] = tmo_set | (m_tmo[k] & !clear_i);
      end
    end
    if (cs_w[0] === 1'b1) st_ch0.push_back(cch_w[0]);
    if (tick_w[0] === 1'b1) begin
      tick_cnt0++;
      if (first_tick0 < 0) first_tick0 = cyc;
    end
    if (sv_w[1] === 1'b1) sv_cnt1++;
    cyc++;
  end

  // converter responder, keyed on the model's predicted starts of the second instance
  initial begin
    forever begin
      @(posedge clk);
      #1;
      conv_valid_i = (cyc == reply_at) || (spur_en && $urandom_range(0, 49) == 0);
      conv_data_i  = data_fixed ? 16'h1234 : 16'($urandom);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_wd();
    int t = 0;
    while (!(m_busy[1] && cyc > m_start_at[1]) && t < 60) begin
      step(1);
      t++;
    end
    chk("wait_wait_data", 32'(t < 60), 1);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_svld"}, sv_w[0], 0);
    chk({pfx, "_sdat"}, sd_w[0], 0);
    chk({pfx, "_sch"},  sch_w[0], 0);
    chk({pfx, "_cch"},  cch_w[0], 0);
    chk({pfx, "_ovr"},  ovr_w[0], 0);
    chk({pfx, "_tmo"},  tmo_w[0], 0);
    chk({pfx, "_start"}, cs_w[0], 0);
  endtask

  initial begin
    int en_cyc;
    int n;
    step(3);
    chk_on = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("rst");
    chk("rst_tick", tick_w[0], 0);

    // mask 0: ticks every DIV cycles, no conversions, stray converter strobes ignored
    step(1);
    spur_en = 1'b1;
    enable_i = 1'b1;
    en_cyc = cyc;
    tick_cnt0 = 0;
    first_tick0 = -1;
    st_ch0.delete();
    step(42);
    chk("first_tick_lat", first_tick0 - en_cyc, 10);
    chk("tick_count", tick_cnt0, 4);
    chk("mask0_starts", st_ch0.size(), 0);

    // round robin over 1011 with a 3-cycle converter
    spur_en = 1'b0;
    mask_i = 4'b1011;
    reply_delay = 3;
    data_fixed = 1'b1;
    st_ch0.delete();
    step(45);
    n = st_ch0.size();
    chk("rr_nstarts", 32'(n >= 4), 1);
    chk("rr_ch0", (n > 0) ? st_ch0[0] : -1, 0);
    chk("rr_ch1", (n > 1) ? st_ch0[1] : -1, 1);
    chk("rr_ch2", (n > 2) ? st_ch0[2] : -1, 3);
    chk("rr_ch3", (n > 3) ? st_ch0[3] : -1, 0);
    chk("rr_data", sd_w[0], 16'h1234);
    data_fixed = 1'b0;

    // silent converter: timeouts, then clear
    reply_delay = 0;
    step(30);
    chk("tmo_seen", tmo_w[0], 1);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    step(25);

    // slow converter: overrun on the second instance, sample still delivered
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    reply_delay = 12;
    sv_cnt1 = 0;
    step(60);
    chk("ovr_seen", ovr_w[1], 1);
    chk("slow_samples", 32'(sv_cnt1 > 0), 1);

    // one-cycle reset while waiting for data, followed by a late reply
    reply_delay = 5;
    wait_wd();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    st_ch0.delete();
    @(negedge clk);
    chk_zero("midrst");
    step(25);
    chk("post_rst_ch", (st_ch0.size() > 0) ? st_ch0[0] : -1, 0);

    // enable dropped while waiting for data
    reply_delay = 4;
    wait_wd();
    enable_i = 1'b0;
    step(3);
    enable_i = 1'b1;
    step(30);

    // randomized run
    rand_delay = 1'b1;
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mask_i = 4'($urandom_range(0, 15));
      enable_i = ($urandom_range(0, 99) != 0);
      clear_i  = ($urandom_range(0, 32) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      step(1);
    end
    rst_n = 1'b1;
    clear_i = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
